trace_request_queue: RTL and testbench

Timed admission queue placed directly downstream of the trace parser in the DDR5 memory controller. It accepts parsed trace entries (CPU time, core, operation, address) over a valid/ready handshake. Each entry is held until the internal CPU-cycle counter reaches its trace time, then buffered in order in a FIFO. Entries leave with the address decoded into DDR5 fields, ready for the command scheduler.

---
 rtl/ddr5_pkg.sv | 44 ++++
 rtl/sync_fifo.sv | 52 +++++
 rtl/trace_request_queue.sv | 116 +++++++++++
 tb/tb_trace_request_queue.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr5_pkg.sv
// DDR5 address-map types and field positions shared by the trace admission path.
// decode_addr() splits a 34-bit byte address into row/column/bank/bank-group/channel.
package ddr5_pkg;

  typedef enum logic [1:0] {
    READ   = 2'd0,
    WRITE  = 2'd1,
    IFETCH = 2'd2
  } opn_e;

  localparam logic [1:0] OPN_ILLEGAL = 2'd3;

  localparam int DRAM_ADDR_BITS = 34;
  localparam int ROW_MSB        = 33;
  localparam int ROW_LSB        = 18;
  localparam int COL_HI_MSB     = 17;
  localparam int COL_HI_LSB     = 12;
  localparam int BANK_MSB       = 11;
  localparam int BANK_LSB       = 10;
  localparam int BG_MSB         = 9;
  localparam int BG_LSB         = 7;
  localparam int CHAN_BIT       = 6;
  localparam int COL_LO_MSB     = 5;
  localparam int COL_LO_LSB     = 2;

  typedef struct packed {
    logic [15:0] row;
    logic [9:0]  col;
    logic [1:0]  bank;
    logic [2:0]  bg;
    logic        chan;
  } dram_addr_t;

  function automatic dram_addr_t decode_addr(input logic [DRAM_ADDR_BITS-1:0] addr);
    dram_addr_t d;
    d.row  = addr[ROW_MSB:ROW_LSB];
    d.col  = {addr[COL_HI_MSB:COL_HI_LSB], addr[COL_LO_MSB:COL_LO_LSB]};
    d.bank = addr[BANK_MSB:BANK_LSB];
    d.bg   = addr[BG_MSB:BG_LSB];
    d.chan = addr[CHAN_BIT];
    return d;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock circular FIFO with occupancy count. Read data is the head entry,
// forced to zero while empty so downstream fields read 0 out of reset.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A write into a full buffer is only legal when the head leaves on the same edge.
  assign do_push = push && (!full || do_pop);
  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/trace_request_queue.sv
// Timed admission queue: holds each parsed trace entry until the CPU-cycle counter
// reaches its time, then queues it in order and presents it with DDR5 fields decoded.
module trace_request_queue
  import ddr5_pkg::*;
#(
  parameter int MEM_ADDR_WIDTH = 34,
  parameter int TIME_WIDTH     = 64,
  parameter int CPU_CORE_WIDTH = 4,
  parameter int MEM_OPN_WIDTH  = 2,
  parameter int DEPTH          = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [TIME_WIDTH-1:0]     in_time,
  input  logic [CPU_CORE_WIDTH-1:0] in_core,
  input  logic [MEM_OPN_WIDTH-1:0]  in_opn,
  input  logic [MEM_ADDR_WIDTH-1:0] in_addr,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [TIME_WIDTH-1:0]     out_time,
  output logic [CPU_CORE_WIDTH-1:0] out_core,
  output logic [MEM_OPN_WIDTH-1:0]  out_opn,
  output logic [15:0]               out_row,
  output logic [9:0]                out_col,
  output logic [1:0]                out_bank,
  output logic [2:0]                out_bg,
  output logic                      out_chan,
  output logic [TIME_WIDTH-1:0]     cur_time,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      full,
  output logic                      err_illegal
);
  localparam int EW = TIME_WIDTH + CPU_CORE_WIDTH + MEM_OPN_WIDTH + MEM_ADDR_WIDTH;

  logic                      stage_valid;
  logic [TIME_WIDTH-1:0]     stage_time;
  logic [CPU_CORE_WIDTH-1:0] stage_core;
  logic [MEM_OPN_WIDTH-1:0]  stage_opn;
  logic [MEM_ADDR_WIDTH-1:0] stage_addr;

  logic             stage_illegal;
  logic             stage_release;
  logic             push;
  logic             pop;
  logic             fifo_empty;
  logic             fast_forward;
  logic [EW-1:0]    head;
  logic [MEM_ADDR_WIDTH-1:0] head_addr;
  dram_addr_t       head_dec;

  assign pop           = out_valid && out_ready;
  assign stage_illegal = (stage_opn == MEM_OPN_WIDTH'(OPN_ILLEGAL));
  // Illegal entries are dropped, so they never wait on FIFO space.
  assign stage_release = stage_valid && (stage_time <= cur_time) &&
                         (stage_illegal || !full || pop);
  assign push          = stage_release && !stage_illegal;
  assign in_ready      = !stage_valid || stage_release;

  // Skip dead cycles when nothing is queued and the staged entry is far in the future.
  assign fast_forward = fifo_empty && stage_valid &&
                        ({1'b0, stage_time} > ({1'b0, cur_time} + (TIME_WIDTH+1)'(1)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_valid <= 1'b0;
      stage_time  <= '0;
      stage_core  <= '0;
      stage_opn   <= '0;
      stage_addr  <= '0;
      cur_time    <= '0;
      err_illegal <= 1'b0;
    end else begin
      if (in_valid && in_ready) begin
        stage_valid <= 1'b1;
        stage_time  <= in_time;
        stage_core  <= in_core;
        stage_opn   <= in_opn;
        stage_addr  <= in_addr;
      end else if (stage_release) begin
        stage_valid <= 1'b0;
      end

      if (fast_forward)        cur_time <= stage_time;
      else if (cur_time != '1) cur_time <= cur_time + TIME_WIDTH'(1);

      err_illegal <= stage_release && stage_illegal;
    end
  end

  sync_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .wr_data ({stage_time, stage_core, stage_opn, stage_addr}),
    .pop     (pop),
    .rd_data (head),
    .count   (count),
    .full    (full),
    .empty   (fifo_empty)
  );

  assign out_valid = !fifo_empty;
  assign {out_time, out_core, out_opn, head_addr} = head;
  assign head_dec  = decode_addr(DRAM_ADDR_BITS'(head_addr));
  assign out_row   = head_dec.row;
  assign out_col   = head_dec.col;
  assign out_bank  = head_dec.bank;
  assign out_bg    = head_dec.bg;
  assign out_chan  = head_dec.chan;

endmodule

// File: tb/tb_trace_request_queue.sv
// Scoreboard bench for trace_request_queue: stimulus pushes expected heads, a
// negedge monitor pops and compares every consumed head.
module tb_trace_request_queue;
  localparam int TW = 64, CW = 4, OW = 2, AW = 34, DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [TW-1:0] in_time = '0;
  logic [CW-1:0] in_core = '0;
  logic [OW-1:0] in_opn = '0;
  logic [AW-1:0] in_addr = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [TW-1:0] out_time;
  logic [CW-1:0] out_core;
  logic [OW-1:0] out_opn;
  logic [15:0]   out_row;
  logic [9:0]    out_col;
  logic [1:0]    out_bank;
  logic [2:0]    out_bg;
  logic          out_chan;
  logic [TW-1:0] cur_time;
  logic [$clog2(DEPTH):0] count;
  logic          full;
  logic          err_illegal;

  typedef logic [101:0] exp_t;
  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   max_count = 0;

  trace_request_queue #(
    .MEM_ADDR_WIDTH (AW),
    .TIME_WIDTH     (TW),
    .CPU_CORE_WIDTH (CW),
    .MEM_OPN_WIDTH  (OW),
    .DEPTH          (DEPTH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_time     (in_time),
    .in_core     (in_core),
    .in_opn      (in_opn),
    .in_addr     (in_addr),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_time    (out_time),
    .out_core    (out_core),
    .out_opn     (out_opn),
    .out_row     (out_row),
    .out_col     (out_col),
    .out_bank    (out_bank),
    .out_bg      (out_bg),
    .out_chan    (out_chan),
    .cur_time    (cur_time),
    .count       (count),
    .full        (full),
    .err_illegal (err_illegal)
  );

  always #5 clk = ~clk;

  // Expected head: {time, core, opn, row, col, bank, bg, chan}
  function automatic exp_t make_exp(input logic [TW-1:0] t, input logic [CW-1:0] c,
                                    input logic [OW-1:0] o, input logic [AW-1:0] a);
    return {t, c, o, a[33:18], a[17:12], a[5:2], a[11:10], a[9:7], a[6]};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (int'(count) > max_count) max_count = int'(count);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pop", {26'b0, out_time, out_core, out_opn, out_row, out_col,
                                   out_bank, out_bg, out_chan}, 128'hDEAD);
        end else begin
          e = exp_q.pop_front();
          check("head", {26'b0, out_time, out_core, out_opn, out_row, out_col,
                         out_bank, out_bg, out_chan}, {26'b0, e});
          $display("pop time=%0d core=%0d opn=%0d row=0x%0h col=0x%0h bank=%0d bg=%0d chan=%0d",
                   out_time, out_core, out_opn, out_row, out_col, out_bank, out_bg, out_chan);
        end
      end
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic send(input logic [TW-1:0] t, input logic [CW-1:0] c,
                      input logic [OW-1:0] o, input logic [AW-1:0] a);
    bit ok = 1'b0;
    in_valid = 1'b1;
    in_time = t;
    in_core = c;
    in_opn = o;
    in_addr = a;
    for (int i = 0; i < 300; i++) begin
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) check("send_timeout", 0, 1);
    @(posedge clk);
    if (ok && o != 2'd3) exp_q.push_back(make_exp(t, c, o, a));
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    bit ok = 1'b0;
    @(posedge clk);
    #1 out_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !out_valid) begin
        ok = 1'b1;
        break;
      end
    end
    check("drain", ok, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values while held in reset
    #12;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_count", count, 0);
    check("rst_full", full, 0);
    check("rst_err", err_illegal, 0);
    check("rst_cur_time", cur_time, 0);
    check("rst_data", {out_time, out_row, out_col}, 0);

    // Basic timing with idle fast-forward
    do_reset();
    send(64'd5, 4'd1, 2'd0, 34'h3_DEAD_BEEF);
    @(negedge clk);
    check("basic_cur_time_e0", cur_time, 1);
    @(posedge clk);
    @(negedge clk);
    check("basic_cur_time_e1", cur_time, 5);
    check("basic_valid_e1", out_valid, 0);
    @(posedge clk);
    @(negedge clk);
    check("basic_valid_e2", out_valid, 1);
    check("basic_count_e2", count, 1);
    // Field values re-derived from the bit positions of 0x3_DEAD_BEEF
    check("basic_row", out_row, 16'hF7AB);
    check("basic_col", out_col, 10'h1BB);
    check("basic_bank", out_bank, 2'd3);
    check("basic_bg", out_bg, 3'd5);
    check("basic_chan", out_chan, 1'b1);
    wait_drain();

    // Fill and stall
    do_reset();
    for (int i = 0; i < 17; i++)
      send(64'd0, CW'(i), OW'(i % 3), AW'(i) * 34'h0_0123_4567);
    @(negedge clk);
    check("fill_count", count, 16);
    check("fill_full", full, 1);
    check("fill_in_ready", in_ready, 0);
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    check("stall_count", count, 16);
    check("stall_full", full, 1);
    check("stall_in_ready", in_ready, 1);
    wait_drain();

    // Illegal op dropped
    do_reset();
    send(64'd0, 4'd2, 2'd3, 34'h123);
    @(negedge clk);
    check("illegal_err_pre", err_illegal, 0);
    @(negedge clk);
    check("illegal_err_pulse", err_illegal, 1);
    check("illegal_count", count, 0);
    @(negedge clk);
    check("illegal_err_post", err_illegal, 0);
    check("illegal_in_ready", in_ready, 1);
    send(64'd0, 4'd3, 2'd1, 34'h2_0000_0040);
    @(negedge clk);
    @(negedge clk);
    check("illegal_next_count", count, 1);
    wait_drain();

    // Out-of-order trace times
    do_reset();
    out_ready = 1'b1;
    send(64'd100, 4'd4, 2'd0, 34'h1_1111_1111);
    send(64'd50, 4'd5, 2'd1, 34'h2_2222_2222);
    @(negedge clk);
    @(negedge clk);
    check("ooo_valid", out_valid, 1);
    check("ooo_time50", out_time, 50);
    send(64'd200, 4'd6, 2'd2, 34'h3_3333_3333);
    wait_drain();

    // Reset mid-stream
    do_reset();
    for (int i = 0; i < 6; i++)
      send(64'd0, CW'(i + 8), 2'd0, AW'(i) << 6);
    @(negedge clk);
    check("midrst_count_pre", count, 5);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("midrst_count", count, 0);
    check("midrst_valid", out_valid, 0);
    check("midrst_full", full, 0);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_cur_time", cur_time, 0);
    check("midrst_data", {out_time, out_core, out_row}, 0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("midrst_stage_gone", out_valid, 0);

    // Pointer wrap with continuous push/pop
    do_reset();
    out_ready = 1'b1;
    max_count = 0;
    for (int i = 0; i < 40; i++)
      send(64'd0, CW'(i), OW'(i % 3), AW'(i) * 34'h0_9E37_79B9);
    wait_drain();
    check("wrap_max_count", max_count, 1);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
